adder_self_test: RTL and testbench

ADDER_SELF_TEST -- requirements
Module: adder_self_test

---
 rtl/adder_test_pkg.sv | 28 ++
 rtl/adder_test_checker.sv | 23 ++
 rtl/adder_self_test.sv | 162 ++++++++++++++++
 tb/tb_adder_self_test.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_test_pkg.sv
// Shared types and constants for the exhaustive 3-bit adder self-test.
// Holds the FSM state encoding, operand/sum widths and the fault-injection vector.
package adder_test_pkg;

    localparam int OPERAND_W   = 3;
    localparam int SUM_W       = 4;
    localparam int NUM_VECTORS = 64;
    localparam int IDX_W       = 6;
    localparam int ERR_W       = 7;
    localparam int SETTLE_W    = 4;

    // Vector a=5, b=2 is the one whose expectation gets perturbed when injection is armed.
    localparam logic [IDX_W-1:0] FAULT_VEC = 6'o52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    function automatic logic [SUM_W-1:0] golden_sum(input logic [OPERAND_W-1:0] a,
                                                     input logic [OPERAND_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_test_checker.sv
// Combinational comparator: flags a mismatch between the returned sum and the expected
// sum, optionally perturbing the expectation for the injection vector.
module adder_test_checker
    import adder_test_pkg::*;
(
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    input  logic [SUM_W-1:0]     sum_i,
    input  logic                 inject_i,
    output logic                 mismatch_o
);

    logic [SUM_W-1:0] expected;

    always_comb begin
        expected = golden_sum(a_i, b_i);
        if (inject_i && ({a_i, b_i} == FAULT_VEC)) begin
            expected = expected ^ 4'b0001;
        end
        mismatch_o = (sum_i != expected);
    end

endmodule

// File: rtl/adder_self_test.sv
// Exhaustive self-test of an external 3-bit adder: walks all 64 operand pairs and counts mismatches.
// Optional fault-injection input is enabled by defining ADDER_SELF_TEST_FAULT_INJECT_EN.
module adder_self_test
    import adder_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef ADDER_SELF_TEST_FAULT_INJECT_EN
    input  logic                 inject_fault,
`endif
    output logic [OPERAND_W-1:0] a_out,
    output logic [OPERAND_W-1:0] b_out,
    input  logic [SUM_W-1:0]     sum_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [OPERAND_W-1:0] fail_a,
    output logic [OPERAND_W-1:0] fail_b,
    output logic                 fail_valid
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_VECTORS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [OPERAND_W-1:0]  fail_a_q, fail_a_d;
    logic [OPERAND_W-1:0]  fail_b_q, fail_b_d;
    logic                  fail_valid_q, fail_valid_d;
    logic                  inject_q, inject_d;
    logic                  inject_req;
    logic                  mismatch;

`ifdef ADDER_SELF_TEST_FAULT_INJECT_EN
    assign inject_req = inject_fault;
`else
    assign inject_req = 1'b0;
`endif

    // Operands come straight from the vector index, so they stay put for the whole vector.
    assign a_out = idx_q[5:3];
    assign b_out = idx_q[2:0];

    adder_test_checker u_checker (
        .a_i        (a_out),
        .b_i        (b_out),
        .sum_i      (sum_in),
        .inject_i   (inject_q),
        .mismatch_o (mismatch)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_valid_d = fail_valid_q;
        inject_d     = inject_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    idx_d        = '0;
                    err_d        = '0;
                    fail_a_d     = '0;
                    fail_b_d     = '0;
                    fail_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    inject_d     = inject_req;
                end
            end
            ST_DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fail_valid_q) begin
                        fail_a_d     = a_out;
                        fail_b_d     = b_out;
                        fail_valid_d = 1'b1;
                    end
                end
                // The index never wraps: the last vector ends the run in DONE.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_valid_q <= 1'b0;
            inject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_valid_q <= fail_valid_d;
            inject_q     <= inject_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
    assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_adder_self_test.sv
// Bench for adder_self_test: three instances (SETTLE_CYCLES 2, 1, 15) driven from one
// directed sequence; the main instance's adder is a lookup table the bench corrupts.
module tb_adder_self_test;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic inject = 1'b0;

    always #5 clk = ~clk;

    logic [2:0] a2, b2, a1, b1, a15, b15;
    logic [3:0] s2, s1, s15;
    logic busy2, done2, pass2, fv2, busy1, done1, pass1, fv1, busy15, done15, pass15, fv15;
    logic [6:0] err2, err1, err15;
    logic [2:0] fa2, fb2, fa1, fb1, fa15, fb15;

    logic [3:0] sum_tbl [64];

    always_comb s2 = sum_tbl[{a2, b2}];
    assign s1  = {1'b0, a1} + {1'b0, b1};
    assign s15 = {1'b0, a15} + {1'b0, b15};

    adder_self_test #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDER_SELF_TEST_FAULT_INJECT_EN
        .inject_fault(inject),
`endif
        .a_out(a2), .b_out(b2), .sum_in(s2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_a(fa2), .fail_b(fb2), .fail_valid(fv2));

    adder_self_test #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDER_SELF_TEST_FAULT_INJECT_EN
        .inject_fault(1'b0),
`endif
        .a_out(a1), .b_out(b1), .sum_in(s1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_a(fa1), .fail_b(fb1), .fail_valid(fv1));

    adder_self_test #(.SETTLE_CYCLES(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDER_SELF_TEST_FAULT_INJECT_EN
        .inject_fault(1'b0),
`endif
        .a_out(a15), .b_out(b15), .sum_in(s15), .busy(busy15), .done(done15), .pass(pass15),
        .err_count(err15), .fail_a(fa15), .fail_b(fb15), .fail_valid(fv15));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Reference model: a correct adder returns a+b; anything else in the table is a mismatch.
    function automatic int true_sum(input int i);
        return (i / 8) + (i % 8);
    endfunction

    function automatic int model_errs();
        int n = 0;
        for (int i = 0; i < 64; i++) if (int'(sum_tbl[i]) != true_sum(i)) n++;
        return n;
    endfunction

    function automatic int model_first();
        for (int i = 0; i < 64; i++) if (int'(sum_tbl[i]) != true_sum(i)) return i;
        return 0;
    endfunction

    task automatic load_correct();
        for (int i = 0; i < 64; i++) sum_tbl[i] = 4'(true_sum(i));
    endtask

    // Pulses start, then counts edges after the accepting edge until main done (-1 on timeout).
    task automatic run_main(output int edges);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        edges = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int e, f;
        e = model_errs();
        f = model_first();
        check({tag, "_err"}, 32'(err2), 32'(e));
        check({tag, "_fv"}, 32'(fv2), 32'(e != 0));
        check({tag, "_pass"}, 32'(pass2), 32'(e == 0));
        if (e != 0) begin
            check({tag, "_fa"}, 32'(fa2), 32'(f / 8));
            check({tag, "_fb"}, 32'(fb2), 32'(f % 8));
        end
    endtask

    initial begin
        int edges, t1, t2, t15, rises, nbad, pos;
        logic prev;

        load_correct();
        #1;
        check("rst_a", 32'(a2), 0);
        check("rst_b", 32'(b2), 0);
        check("rst_busy", 32'(busy2), 0);
        check("rst_done", 32'(done2), 0);
        check("rst_pass", 32'(pass2), 0);
        check("rst_err", 32'(err2), 0);
        check("rst_fv", 32'(fv2), 0);
        check("rst_fa", 32'(fa2), 0);
        #20;
        @(negedge clk) rst_n = 1'b1;

        // Run length for all three settle settings from one start pulse.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        t1 = 0; t2 = 0; t15 = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("busy_after_accept", 32'(busy2), 1);
            if (done1 && t1 == 0) t1 = k;
            if (done2 && t2 == 0) t2 = k;
            if (done15 && t15 == 0) t15 = k;
            if (t15 != 0) break;
        end
        check("len_s2", 32'(t2), 32'(64 * (2 + 2)));
        check("len_s1", 32'(t1), 32'(64 * (1 + 2)));
        check("len_s15", 32'(t15), 32'(64 * (15 + 2)));
        check("pass_s2", 32'(pass2), 1);
        check("pass_s1", 32'(pass1), 1);
        check("pass_s15", 32'(pass15), 1);
        check("err_s15", 32'(err15), 0);
        check("busy_done", 32'(busy2), 0);
        check("done_a", 32'(a2), 7);
        check("done_b", 32'(b2), 7);

        // Sum bit 3 stuck at zero.
        for (int i = 0; i < 64; i++) sum_tbl[i] = 4'(true_sum(i)) & 4'b0111;
        run_main(edges);
        check("stuck_len", 32'(edges), 256);
        check_model("stuck");

        // Start in DONE clears results on the accepting edge.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        check("restart_err", 32'(err2), 0);
        check("restart_fv", 32'(fv2), 0);
        check("restart_busy", 32'(busy2), 1);
        check("restart_done", 32'(done2), 0);
        check("restart_a", 32'(a2), 0);
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 400 && !done2; k++) @(posedge clk);
        #1;

        // Random corruptions of the adder table.
        for (int r = 0; r < 4; r++) begin
            load_correct();
            nbad = int'($urandom_range(0, 6));
            for (int j = 0; j < nbad; j++) begin
                pos = int'($urandom_range(0, 63));
                sum_tbl[pos] = sum_tbl[pos] ^ 4'($urandom_range(1, 15));
            end
            run_main(edges);
            check("rand_len", 32'(edges), 256);
            check_model("rand");
        end

        // Start toggling every cycle during a run is ignored.
        load_correct();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        t2 = 0; rises = 0; prev = done2;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk) start = (k < 250) ? ~start : 1'b0;
            @(posedge clk);
            #1;
            if (done2 && !prev) rises++;
            if (done2 && t2 == 0) t2 = k;
            prev = done2;
        end
        check("toggle_len", 32'(t2), 256);
        check("toggle_rises", 32'(rises), 1);
        check("toggle_pass", 32'(pass2), 1);

        // Asynchronous reset at vector 20 (a=2, b=4).
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        edges = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if ({a2, b2} == 6'd20) begin
                edges = k;
                break;
            end
        end
        check("reach_vec20", 32'(edges >= 0), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_a", 32'(a2), 0);
        check("mid_rst_b", 32'(b2), 0);
        check("mid_rst_busy", 32'(busy2), 0);
        check("mid_rst_err", 32'(err2), 0);
        check("mid_rst_done", 32'(done2), 0);
        @(negedge clk) rst_n = 1'b1;
        run_main(edges);
        check("post_rst_len", 32'(edges), 256);
        check("post_rst_pass", 32'(pass2), 1);

`ifdef ADDER_SELF_TEST_FAULT_INJECT_EN
        inject = 1'b1;
        run_main(edges);
        inject = 1'b0;
        check("inj_err", 32'(err2), 1);
        check("inj_fa", 32'(fa2), 5);
        check("inj_fb", 32'(fb2), 2);
        check("inj_pass", 32'(pass2), 0);
        run_main(edges);
        check("noinj_pass", 32'(pass2), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
